// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter (data bits, parity, stop bits, bit period)
module uart_tx_cfg #(
  parameter int CLK_DIV   = 10417,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = 4;

  // Refuse to build with parameter values the datapath does not support.
  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_tx_cfg: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 baud_last;

  assign baud_last = (baud_q == CW'(CLK_DIV - 1));

  // Next-state and next-output logic; txd_d is the line level for the next cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        txd_d  = 1'b1;
        if (tx_valid) begin
          state_d = S_START;
          shift_d = tx_data;
          par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and returns the line to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = (state_q == S_IDLE) && !rst;
  assign tx_busy  = (state_q != S_IDLE);
  assign txd      = txd_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg over four parameter sets
module tb_uart_tx_cfg;

  localparam int N = 4;
  localparam int CD [N] = '{4, 4, 4, 3};
  localparam int DB [N] = '{8, 8, 8, 7};
  localparam int PAR[N] = '{0, 1, 2, 0};
  localparam int SB [N] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_i [N];
  logic [8:0] tdata [N];
  logic       tvalid[N];
  logic       trdy  [N];
  logic       txd   [N];
  logic       busy  [N];
  logic       done  [N];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_cfg #(
      .CLK_DIV  (CD[g]),
      .DATA_BITS(DB[g]),
      .PARITY   (PAR[g]),
      .STOP_BITS(SB[g])
    ) u_dut (
      .clk     (clk),
      .rst     (rst_i[g]),
      .tx_data (tdata[g][DB[g]-1:0]),
      .tx_valid(tvalid[g]),
      .tx_ready(trdy[g]),
      .txd     (txd[g]),
      .tx_busy (busy[g]),
      .tx_done (done[g])
    );
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bit levels, each lasting CD cycles.
  bit m_in  [N];
  bit m_done[N];
  int m_pos [N];
  int m_len [N];
  bit m_fb  [N][16];
  logic e_txd, e_busy, e_rdy, e_done;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        if (m_in[i]) begin
          e_txd = m_fb[i][m_pos[i] / CD[i]];
          e_busy = 1'b1; e_rdy = 1'b0; e_done = 1'b0;
        end else begin
          e_txd = 1'b1; e_busy = 1'b0; e_rdy = !rst_i[i]; e_done = m_done[i];
        end
        chk("mon_txd",   i, {31'd0, txd[i]},  {31'd0, e_txd});
        chk("mon_busy",  i, {31'd0, busy[i]}, {31'd0, e_busy});
        chk("mon_ready", i, {31'd0, trdy[i]}, {31'd0, e_rdy});
        chk("mon_done",  i, {31'd0, done[i]}, {31'd0, e_done});
        if (rst_i[i]) begin
          m_in[i] = 1'b0;
          m_done[i] = 1'b0;
        end else if (m_in[i]) begin
          m_pos[i]++;
          if (m_pos[i] == m_len[i]) begin
            m_in[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end else begin
          m_done[i] = 1'b0;
          if (tvalid[i] && e_rdy) begin
            int ones;
            int n;
            ones = 0;
            m_fb[i][0] = 1'b0;
            for (int b = 0; b < DB[i]; b++) begin
              m_fb[i][1 + b] = tdata[i][b];
              ones += int'(tdata[i][b]);
            end
            n = 1 + DB[i];
            if (PAR[i] != 0) begin
              m_fb[i][n] = (PAR[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
              n++;
            end
            for (int s = 0; s < SB[i]; s++) begin
              m_fb[i][n] = 1'b1;
              n++;
            end
            m_len[i] = n * CD[i];
            m_pos[i] = 0;
            m_in[i] = 1'b1;
          end
        end
      end
    end
  end

  // Present one character and hold it until accepted; returns just after the accept edge.
  task automatic send(input int i, input logic [8:0] d);
    int w;
    @(posedge clk); #2;
    tvalid[i] = 1'b1;
    tdata[i]  = d;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (trdy[i]) break;
      w++;
      if (w > 500) begin
        chk("accept_timeout", i, 0, 1);
        break;
      end
    end
    @(posedge clk); #2;
    tvalid[i] = 1'b0;
    tdata[i]  = 9'($urandom);
  endtask

  // Compare a just-accepted frame against a hand-written bit list (bit 0 = start bit).
  task automatic pin_frame(input int i, input logic [15:0] bits, input int nb, input int exp_len, input string name);
    int nbusy;
    int ndone;
    nbusy = 0;
    ndone = 0;
    for (int k = 0; k < nb * CD[i]; k++) begin
      @(negedge clk);
      if (busy[i]) nbusy++;
      if (done[i]) ndone++;
      if (k % CD[i] == 0) chk({name, "_bit"}, i, {31'd0, txd[i]}, {31'd0, bits[k / CD[i]]});
    end
    @(negedge clk);
    chk({name, "_len"},      i, nbusy, exp_len);
    chk({name, "_no_early"}, i, ndone, 0);
    chk({name, "_done"},     i, {31'd0, done[i]}, 1);
    chk({name, "_idle"},     i, {31'd0, busy[i]}, 0);
    chk({name, "_ready"},    i, {31'd0, trdy[i]}, 1);
  endtask

  task automatic b2b;
    int idx, nacc, nbusy, d1, s2, d2, ndone;
    idx = -1; nacc = 0; nbusy = 0; d1 = -1; s2 = -1; d2 = -1; ndone = 0;
    @(posedge clk); #2;
    tvalid[0] = 1'b1;
    tdata[0]  = 9'h0A5;
    for (int k = 0; k < 300 && d2 < 0; k++) begin
      @(negedge clk);
      if (nacc > 0) begin
        idx++;
        if (busy[0]) nbusy++;
        if (done[0]) begin
          ndone++;
          if (d1 < 0) d1 = idx; else d2 = idx;
        end
        if (d1 >= 0 && s2 < 0 && busy[0]) s2 = idx;
      end
      if (trdy[0] && tvalid[0]) begin
        nacc++;
        @(posedge clk); #2;
        if (nacc == 1) tdata[0] = 9'h03C;
        else tvalid[0] = 1'b0;
      end
    end
    chk("b2b_done1",  0, d1, 40);
    chk("b2b_start2", 0, s2, 41);
    chk("b2b_done2",  0, d2, 81);
    chk("b2b_busy",   0, nbusy, 80);
    chk("b2b_ndone",  0, ndone, 2);
  endtask

  initial begin
    int nd;
    for (int i = 0; i < N; i++) begin
      rst_i[i] = 1'b1; tvalid[i] = 1'b0; tdata[i] = '0;
      m_in[i] = 1'b0; m_done[i] = 1'b0; m_pos[i] = 0; m_len[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_txd",   i, {31'd0, txd[i]},  1);
      chk("rst_busy",  i, {31'd0, busy[i]}, 0);
      chk("rst_ready", i, {31'd0, trdy[i]}, 0);
      chk("rst_done",  i, {31'd0, done[i]}, 0);
    end
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) rst_i[i] = 1'b0;
    @(negedge clk);
    chk("rel_ready", 0, {31'd0, trdy[0]}, 1);

    send(0, 9'h055); pin_frame(0, 16'b1_01010101_0,    10, 40, "f55_8n1");
    send(1, 9'h007); pin_frame(1, 16'b1_0_00000111_0,  11, 44, "f07_odd");
    send(2, 9'h007); pin_frame(2, 16'b1_1_00000111_0,  11, 44, "f07_even");
    send(2, 9'h000); pin_frame(2, 16'b1_0_00000000_0,  11, 44, "f00_even");
    send(3, 9'h041); pin_frame(3, 16'b11_1000001_0,    10, 30, "f41_7n2");

    b2b();
    repeat (5) @(posedge clk);

    send(0, 9'h0FF);
    repeat (16) @(posedge clk);
    #2 rst_i[0] = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", 0, {31'd0, trdy[0]}, 0);
    chk("rstmid_busy",  0, {31'd0, busy[0]}, 1);
    @(posedge clk); #2 rst_i[0] = 1'b0;
    @(negedge clk);
    chk("rstmid_txd",   0, {31'd0, txd[0]},  1);
    chk("rstmid_idle",  0, {31'd0, busy[0]}, 0);
    nd = int'(done[0]);
    repeat (45) begin
      @(negedge clk);
      nd += int'(done[0]);
    end
    chk("rstmid_nodone", 0, nd, 0);
    send(0, 9'h012); pin_frame(0, 16'b1_00010010_0, 10, 40, "f12_after_rst");

    for (int r = 0; r < 32; r++) begin
      send($urandom_range(0, N - 1), 9'($urandom));
      repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    repeat (200) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("drain_idle", i, {31'd0, busy[i]}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
